// File: rtl/online_pkg.sv
// Shared radix-2 signed-digit types and helpers for the online arithmetic blocks.
// A digit is {plus, minus}; 2'b11 is a legal but non-canonical zero.
package online_pkg;

    typedef logic [1:0] digit_t;

    localparam digit_t DIG_ZERO = 2'b00;
    localparam digit_t DIG_POS  = 2'b10;
    localparam digit_t DIG_NEG  = 2'b01;

    localparam int ONLINE_DELAY = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH
    } ccm_state_e;

    function automatic digit_t dig_neg(input digit_t d);
        return {d[0], d[1]};
    endfunction

    function automatic logic signed [1:0] dig_val(input digit_t d);
        case (d)
            DIG_POS: return 2'sb01;
            DIG_NEG: return 2'sb11;
            default: return 2'sb00;
        endcase
    endfunction

    function automatic digit_t dig_enc(input logic signed [1:0] v);
        case (v)
            2'sb01:  return DIG_POS;
            2'sb11:  return DIG_NEG;
            default: return DIG_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/online_adder_serial.sv
// Digit-serial radix-2 signed-digit online adder, online delay 2.
// Each step takes a_k, b_k and registers z_(k-2) on its output.
module online_adder_serial
    import online_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   step,
    input  logic   clr,
    input  digit_t a,
    input  digit_t b,
    output digit_t z
);

    logic signed [2:0] p_q, p_d, p_cur;
    logic signed [1:0] w_q, w_d;
    digit_t            z_q, z_d;
    logic signed [1:0] va, vb, t, w, zs;

    always_comb begin
        va    = dig_val(a);
        vb    = dig_val(b);
        p_cur = {va[1], va} + {vb[1], vb};
        t     = 2'sb00;
        w     = 2'sb00;
        // split p_(k-1) = 2t + w, choosing w so it cannot collide with t_k
        case (p_q)
            3'b010: t = 2'sb01;
            3'b110: t = 2'sb11;
            3'b001: begin
                if (!p_cur[2]) begin
                    t = 2'sb01;
                    w = 2'sb11;
                end else begin
                    w = 2'sb01;
                end
            end
            3'b111: begin
                if (!p_cur[2]) begin
                    w = 2'sb11;
                end else begin
                    t = 2'sb11;
                    w = 2'sb01;
                end
            end
            default: ;
        endcase
        zs  = w_q + t;
        p_d = p_q;
        w_d = w_q;
        z_d = z_q;
        if (clr) begin
            p_d = '0;
            w_d = '0;
            z_d = DIG_ZERO;
        end else if (step) begin
            p_d = p_cur;
            w_d = w;
            z_d = dig_enc(zs);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
            w_q <= '0;
            z_q <= DIG_ZERO;
        end else begin
            p_q <= p_d;
            w_q <= w_d;
            z_q <= z_d;
        end
    end

    assign z = z_q;

endmodule

// File: rtl/online_ccm_serial.sv
// Online constant multiplier y = x*(1 +/- 2^-SHIFT) on MSD-first digit streams.
// Subtract mode exists only when ONLINE_CCM_SUB_EN is defined.
module online_ccm_serial
    import online_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int SHIFT  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_digit,
    input  logic       mode_sub,
    output logic       out_valid,
    output logic [1:0] out_digit,
    output logic       out_first,
    output logic       out_last
);

    localparam int M    = DIGITS + SHIFT;
    localparam int LAST = M + ONLINE_DELAY;
    localparam int CW   = $clog2(LAST + 1);

    ccm_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d, k;
    digit_t [SHIFT-1:0]  dl_q, dl_d;
    logic                emit_q, emit_d, first_q, first_d, last_q, last_d;
    logic                out_valid_q, out_valid_d;
    digit_t              out_digit_q, out_digit_d;
    logic                out_first_q, out_first_d, out_last_q, out_last_d;
    logic                beat, step, clr;
    digit_t              x_in, b_in, z;

    assign in_ready = (state_q != S_FLUSH);
    assign beat     = in_valid & in_ready;
    assign step     = beat | (state_q == S_FLUSH);
    assign k        = cnt_q + CW'(1);
    assign clr      = (state_q == S_IDLE) & ~beat;
    assign x_in     = (beat && in_digit != 2'b11) ? in_digit : DIG_ZERO;

`ifdef ONLINE_CCM_SUB_EN
    logic mode_q, mode_d;

    always_comb begin
        mode_d = mode_q;
        if (state_q == S_IDLE && beat) mode_d = mode_sub;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mode_q <= 1'b0;
        else     mode_q <= mode_d;
    end

    assign b_in = mode_q ? dig_neg(dl_q[SHIFT-1]) : dl_q[SHIFT-1];
`else
    logic unused_mode;
    assign unused_mode = mode_sub;
    assign b_in        = dl_q[SHIFT-1];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (beat) begin
                    state_d = S_LOAD;
                    cnt_d   = CW'(1);
                end
            end
            S_LOAD: begin
                if (beat) begin
                    cnt_d = k;
                    if (k == CW'(DIGITS)) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                cnt_d = k;
                if (k == CW'(LAST)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        dl_d = dl_q;
        if (step) begin
            for (int i = SHIFT - 1; i > 0; i--) dl_d[i] = dl_q[i-1];
            dl_d[0] = x_in;
        end
    end

    // the adder holds z_(k-2) after step k; this stage tags it for the output register
    always_comb begin
        emit_d      = step && (k >= CW'(2));
        first_d     = step && (k == CW'(2));
        last_d      = step && (k == CW'(LAST));
        out_valid_d = emit_q;
        out_digit_d = emit_q ? z : DIG_ZERO;
        out_first_d = first_q;
        out_last_d  = last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dl_q        <= '0;
            emit_q      <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_digit_q <= DIG_ZERO;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dl_q        <= dl_d;
            emit_q      <= emit_d;
            first_q     <= first_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_digit_q <= out_digit_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    online_adder_serial u_add (
        .clk  (clk),
        .rst  (rst),
        .step (step),
        .clr  (clr),
        .a    (x_in),
        .b    (b_in),
        .z    (z)
    );

    assign out_valid = out_valid_q;
    assign out_digit = out_digit_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_online_ccm_serial.sv
// Scoreboard bench for online_ccm_serial with DIGITS=4, SHIFT=1.
// Frame values are rebuilt from output digits and compared with x*(1 +/- 1/2).
`timescale 1ns/1ps
module tb_online_ccm_serial;

    localparam int DIGITS = 4;
    localparam int SHIFT  = 1;
    localparam int M      = DIGITS + SHIFT;
    localparam int NOUT   = M + 1;
`ifdef ONLINE_CCM_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       mode_sub = 1'b0;
    logic [1:0] in_digit = 2'b00;
    logic       in_ready, out_valid, out_first, out_last;
    logic [1:0] out_digit;

    online_ccm_serial #(.DIGITS(DIGITS), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .mode_sub  (mode_sub),
        .out_valid (out_valid),
        .out_digit (out_digit),
        .out_first (out_first),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                  val;
        int                  n;
        bit                  ok;
        int                  fc;
        logic [2*NOUT-1:0]   digs;
    } res_t;

    res_t res_q[$];
    int   exp_q[$];
    int   stray = 0;
    logic [2*NOUT-1:0] half_digs;

    function automatic int dval(input logic [1:0] d);
        if (d == 2'b10) return 1;
        if (d == 2'b01) return -1;
        return 0;
    endfunction

    function automatic int model(input logic [2*DIGITS-1:0] f, input bit sub);
        int x = 0;
        for (int i = 0; i < DIGITS; i++) x = x * 2 + dval(f[2*DIGITS-1-2*i -: 2]);
        return x * (1 << SHIFT) + ((sub && SUB_EN) ? -x : x);
    endfunction

    // output monitor: assembles frames, checks flag placement
    bit                m_act = 1'b0;
    bit                m_ok;
    int                m_acc, m_n, m_fc;
    logic [2*NOUT-1:0] m_digs;

    always @(negedge clk) begin
        if (rst) begin
            m_act = 1'b0;
        end else if (out_valid === 1'b1) begin
            if (out_first === 1'b1) begin
                m_act  = 1'b1;
                m_acc  = 0;
                m_n    = 0;
                m_ok   = 1'b1;
                m_fc   = cyc;
                m_digs = '0;
            end
            if (!m_act) begin
                stray++;
            end else begin
                if (out_digit === 2'b11) m_ok = 1'b0;
                if (out_first !== (m_n == 0)) m_ok = 1'b0;
                if (out_last !== (m_n == M)) m_ok = 1'b0;
                m_acc  = m_acc * 2 + dval(out_digit);
                m_digs = {m_digs[2*NOUT-3:0], out_digit};
                m_n++;
                if (out_last === 1'b1 || m_n > M) begin
                    res_q.push_back('{m_acc, m_n, m_ok, m_fc, m_digs});
                    m_act = 1'b0;
                end
            end
        end
    end

    task automatic send_frame(input logic [2*DIGITS-1:0] f, input bit sub,
                              input bit bub, output int bc, output int w0);
        int w;
        exp_q.push_back(model(f, sub));
        bc = 0;
        w0 = 0;
        for (int i = 0; i < DIGITS; i++) begin
            in_valid = 1'b1;
            in_digit = f[2*DIGITS-1-2*i -: 2];
            mode_sub = (i == 0) ? sub : !sub;
            w = 0;
            while (in_ready !== 1'b1 && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            if (i == 0) begin
                bc = cyc;
                w0 = w;
            end
            @(posedge clk); #1;
            if (bub) begin
                in_valid = 1'b0;
                in_digit = 2'b10;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        in_digit = 2'b00;
    endtask

    task automatic get_res(output res_t r, output int e);
        int t = 0;
        while (res_q.size() == 0 && t < 100) begin
            @(posedge clk); #2;
            t++;
        end
        total++;
        if (res_q.size() == 0 || exp_q.size() == 0) begin
            bad++;
            $display("FAIL result_timeout: got %0d results, required 1", res_q.size());
            r = '{0, 0, 1'b0, 0, '0};
            e = 0;
        end else begin
            r = res_q.pop_front();
            e = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        total += 3;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_in_ready: got %b required 1", in_ready);
        end
        if (out_valid !== 1'b0 || out_first !== 1'b0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL rst_flags: got %b%b%b required 000", out_valid, out_first, out_last);
        end
        if (out_digit !== 2'b00) begin
            bad++;
            $display("FAIL rst_digit: got %b required 00", out_digit);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_half();
        res_t r;
        int e, bc, w0;
        send_frame(8'b10_00_00_00, 1'b0, 1'b0, bc, w0);
        get_res(r, e);
        total += 4;
        if (r.val !== 24 || r.val !== e) begin
            bad++;
            $display("FAIL half_add_value: got %0d/32 required %0d/32", r.val, e);
        end
        if (r.n !== NOUT) begin
            bad++;
            $display("FAIL half_add_count: got %0d required %0d", r.n, NOUT);
        end
        if (!r.ok) begin
            bad++;
            $display("FAIL half_add_flags: got ok=%0d required 1", r.ok);
        end
        if (r.fc - bc !== 3) begin
            bad++;
            $display("FAIL half_add_latency: got %0d required 3", r.fc - bc);
        end
        half_digs = r.digs;
    endtask

    task automatic test_sub_half();
        res_t r;
        int e, bc, w0;
        send_frame(8'b10_00_00_00, 1'b1, 1'b0, bc, w0);
        get_res(r, e);
        total += 2;
        if (r.val !== e || r.val !== (SUB_EN ? 8 : 24)) begin
            bad++;
            $display("FAIL half_sub_value: got %0d/32 required %0d/32", r.val, e);
        end
        if (!r.ok || r.n !== NOUT) begin
            bad++;
            $display("FAIL half_sub_frame: got ok=%0d n=%0d required ok=1 n=%0d", r.ok, r.n, NOUT);
        end
    endtask

    task automatic test_all_ones();
        res_t r;
        int e, bc, w0;
        send_frame(8'b10_10_10_10, 1'b0, 1'b0, bc, w0);
        get_res(r, e);
        total += 3;
        if (r.val !== 45 || r.val !== e) begin
            bad++;
            $display("FAIL pos_value: got %0d/32 required 45/32", r.val);
        end
        if (r.digs[2*NOUT-1 -: 2] === 2'b00) begin
            bad++;
            $display("FAIL pos_z0: got %b required nonzero", r.digs[2*NOUT-1 -: 2]);
        end
        if (!r.ok) begin
            bad++;
            $display("FAIL pos_flags: got ok=%0d required 1", r.ok);
        end
        send_frame(8'b01_01_01_01, 1'b0, 1'b0, bc, w0);
        get_res(r, e);
        total++;
        if (r.val !== -45 || r.val !== e || !r.ok) begin
            bad++;
            $display("FAIL neg_value: got %0d/32 ok=%0d required -45/32", r.val, r.ok);
        end
    endtask

    task automatic test_bubbles();
        res_t r;
        int e, bc, w0;
        send_frame(8'b10_00_00_00, 1'b0, 1'b1, bc, w0);
        get_res(r, e);
        total += 3;
        if (r.digs !== half_digs) begin
            bad++;
            $display("FAIL bubble_digits: got %h required %h", r.digs, half_digs);
        end
        if (r.n !== NOUT || !r.ok) begin
            bad++;
            $display("FAIL bubble_count: got %0d required %0d", r.n, NOUT);
        end
        if (r.val !== e) begin
            bad++;
            $display("FAIL bubble_value: got %0d required %0d", r.val, e);
        end
    endtask

    task automatic test_back_to_back();
        res_t r1, r2;
        int e1, e2, bc1, bc2, w1, w2;
        send_frame(8'b10_10_10_10, 1'b0, 1'b0, bc1, w1);
        send_frame(8'b10_00_00_00, 1'b1, 1'b0, bc2, w2);
        get_res(r1, e1);
        get_res(r2, e2);
        total += 5;
        if (w2 !== SHIFT + 2) begin
            bad++;
            $display("FAIL b2b_ready_gap: got %0d required %0d", w2, SHIFT + 2);
        end
        if (bc2 - bc1 !== DIGITS + SHIFT + 2) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d required %0d", bc2 - bc1, DIGITS + SHIFT + 2);
        end
        if (r1.val !== e1 || !r1.ok) begin
            bad++;
            $display("FAIL b2b_first_frame: got %0d required %0d", r1.val, e1);
        end
        if (r2.val !== e2 || !r2.ok) begin
            bad++;
            $display("FAIL b2b_second_frame: got %0d required %0d", r2.val, e2);
        end
        if (r2.fc - r1.fc !== DIGITS + SHIFT + 2) begin
            bad++;
            $display("FAIL b2b_out_spacing: got %0d required %0d", r2.fc - r1.fc, DIGITS + SHIFT + 2);
        end
    endtask

    task automatic test_reset_mid();
        res_t r;
        int e, bc, w0;
        in_valid = 1'b1;
        mode_sub = 1'b1;
        in_digit = 2'b10;
        @(posedge clk); #1;
        in_digit = 2'b01;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_digit !== 2'b00 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_outputs: got v=%b d=%b r=%b required v=0 d=00 r=1",
                     out_valid, out_digit, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        // second abort lands while output digits are streaming
        for (int i = 0; i < DIGITS; i++) begin
            in_valid = 1'b1;
            in_digit = 2'b10;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre_valid: got %b required 1", out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_digit !== 2'b00 || out_first !== 1'b0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL abort_async: got v=%b d=%b f=%b l=%b required 0",
                     out_valid, out_digit, out_first, out_last);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_frame(8'b10_00_00_00, 1'b0, 1'b0, bc, w0);
        get_res(r, e);
        total += 2;
        if (r.val !== 24 || !r.ok || r.fc - bc !== 3) begin
            bad++;
            $display("FAIL abort_next_frame: got %0d/32 lat=%0d required 24/32 lat=3",
                     r.val, r.fc - bc);
        end
        if (res_q.size() !== 0) begin
            bad++;
            $display("FAIL abort_residue: got %0d extra frames required 0", res_q.size());
        end
    endtask

    task automatic test_random();
        res_t r;
        int e, bc, w0;
        logic [2*DIGITS-1:0] f;
        for (int n = 0; n < 8; n++) begin
            f = 8'($urandom);
            send_frame(f, 1'($urandom), 1'($urandom), bc, w0);
            get_res(r, e);
            total++;
            if (r.val !== e || !r.ok || r.n !== NOUT) begin
                bad++;
                $display("FAIL random_%0d: x=%b got %0d n=%0d required %0d n=%0d",
                         n, f, r.val, r.n, e, NOUT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_half();
        test_sub_half();
        test_all_ones();
        test_bubbles();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (12) @(posedge clk);
        #1;
        total++;
        if (stray !== 0 || exp_q.size() !== 0 || res_q.size() !== 0) begin
            bad++;
            $display("FAIL leftovers: got stray=%0d exp=%0d res=%0d required 0",
                     stray, exp_q.size(), res_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
